// File: rtl/edge_px_packer_if.sv
// Word write channel from edge_px_packer to the edge frame-buffer BRAM writer.
// wr_valid/wr_ready: a word transfers on a clock edge where both are high; once wr_valid is
// raised, wr_addr/wr_data hold steady and wr_valid stays high until that transfer happens.
interface edge_px_packer_if #(
    parameter int ADDR_W = 15
) ();
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/edge_px_packer.sv
// Packs the 1-bit Sobel edge stream into addressed 16-bit BRAM words through a 4-deep FWFT FIFO.
// Optional EDGE_COUNT_EN builds the per-frame edge pixel counter; otherwise edge_count is 0.
module edge_px_packer #(
    parameter logic [15:0] PX_PER_ROW = 16'd520,
    parameter logic [15:0] ROWS       = 16'd390,
    parameter logic [15:0] SKIP       = 16'd522,
    parameter int          ADDR_W     = 15
) (
    input  logic                   CLK100MHZ,
    input  logic                   CPU_RESETN,
    input  logic                   ena,
    input  logic                   edge_px,
    input  logic                   frame_start,
    edge_px_packer_if.master       wr,
    output logic                   frame_done,
    output logic                   overflow,
    output logic [18:0]            edge_count,
    output logic [1:0]             dbg_state_o
);
    typedef enum logic [1:0] {S_IDLE, S_SKIP, S_ACTIVE, S_DONE} state_t;

    state_t            state_q;
    logic [15:0]       skip_q, col_q, row_q, word_q;
    logic [ADDR_W-1:0] addr_q;
    logic              frame_done_q, overflow_q;

    logic [ADDR_W+15:0] mem_q [4];
    logic [1:0]         wptr_q, rptr_q;
    logic [2:0]         count_q;

    logic        accept_d, row_end_d, word_end_d, last_px_d;
    logic        push_d, pop_d, full_d, drop_d, push_ok_d;
    logic [15:0] px_word_d;

    always_comb begin
        accept_d   = (state_q == S_ACTIVE) && ena && !frame_start;
        px_word_d  = word_q | ({15'd0, edge_px} << col_q[3:0]);
        row_end_d  = (col_q == PX_PER_ROW - 16'd1);
        word_end_d = accept_d && ((col_q[3:0] == 4'hF) || row_end_d);
        last_px_d  = accept_d && row_end_d && (row_q == ROWS - 16'd1);
        push_d     = word_end_d;
        pop_d      = wr.wr_valid && wr.wr_ready;
        full_d     = (count_q == 3'd4);
        // A pop in the same cycle frees the slot, so only a push into a full, non-draining FIFO drops.
        drop_d     = push_d && full_d && !pop_d;
        push_ok_d  = push_d && !drop_d;
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q      <= S_IDLE;
            skip_q       <= '0;
            col_q        <= '0;
            row_q        <= '0;
            word_q       <= '0;
            addr_q       <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (frame_start) begin
                state_q    <= (SKIP == 16'd0) ? S_ACTIVE : S_SKIP;
                skip_q     <= '0;
                col_q      <= '0;
                row_q      <= '0;
                word_q     <= '0;
                addr_q     <= '0;
                overflow_q <= 1'b0;
            end else begin
                if (drop_d) overflow_q <= 1'b1;
                case (state_q)
                    S_SKIP: begin
                        if (ena) begin
                            skip_q <= skip_q + 16'd1;
                            if (skip_q == SKIP - 16'd1) state_q <= S_ACTIVE;
                        end
                    end
                    S_ACTIVE: begin
                        if (ena) begin
                            word_q <= word_end_d ? 16'd0 : px_word_d;
                            if (word_end_d) addr_q <= addr_q + ADDR_W'(1);
                            if (row_end_d) begin
                                col_q <= '0;
                                row_q <= row_q + 16'd1;
                            end else begin
                                col_q <= col_q + 16'd1;
                            end
                            if (last_px_d) begin
                                frame_done_q <= 1'b1;
                                state_q      <= S_DONE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Words already addressed survive frame_start; only reset empties the FIFO.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            for (int i = 0; i < 4; i++) mem_q[i] <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok_d) begin
                mem_q[wptr_q] <= {addr_q, px_word_d};
                wptr_q        <= wptr_q + 2'd1;
            end
            if (pop_d) rptr_q <= rptr_q + 2'd1;
            case ({push_ok_d, pop_d})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: ;
            endcase
        end
    end

    assign wr.wr_valid = (count_q != 3'd0);
    assign wr.wr_addr  = mem_q[rptr_q][ADDR_W+15:16];
    assign wr.wr_data  = mem_q[rptr_q][15:0];
    assign frame_done  = frame_done_q;
    assign overflow    = overflow_q;
    assign dbg_state_o = state_q;

`ifdef EDGE_COUNT_EN
    logic [18:0] ecnt_q, ecnt_d, edge_count_q;

    always_comb begin
        ecnt_d = ecnt_q;
        if (accept_d && edge_px && (ecnt_q != 19'h7FFFF)) ecnt_d = ecnt_q + 19'd1;
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            ecnt_q       <= '0;
            edge_count_q <= '0;
        end else if (frame_start) begin
            ecnt_q <= '0;
        end else begin
            ecnt_q <= ecnt_d;
            if (last_px_d) edge_count_q <= ecnt_d;
        end
    end

    assign edge_count = edge_count_q;
`else
    assign edge_count = 19'd0;
`endif
endmodule

// File: tb/tb_edge_px_packer.sv
// Scoreboard bench for edge_px_packer on a reduced 20x3 frame (2 words per row, 4-px tail word).
module tb_edge_px_packer;
  localparam logic [15:0] PX   = 16'd20;
  localparam logic [15:0] ROWS = 16'd3;
  localparam logic [15:0] SKIP = 16'd22;
  localparam int          AW   = 8;
`ifdef EDGE_COUNT_EN
  localparam int EC_EN = 1;
`else
  localparam int EC_EN = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b0, edge_px = 1'b0, frame_start = 1'b0;
  logic frame_done, overflow;
  logic [18:0] edge_count;
  logic [1:0] dbg_state;

  edge_px_packer_if #(.ADDR_W(AW)) wr_if ();

  edge_px_packer #(.PX_PER_ROW(PX), .ROWS(ROWS), .SKIP(SKIP), .ADDR_W(AW)) dut (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rst_n),
    .ena        (ena),
    .edge_px    (edge_px),
    .frame_start(frame_start),
    .wr         (wr_if),
    .frame_done (frame_done),
    .overflow   (overflow),
    .edge_count (edge_count),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  logic [AW+15:0] exp_q[$];
  logic [AW+15:0] mon_e, prev_word;
  bit prev_stall = 1'b0;
  int errors = 0, checks = 0, fd_cnt = 0, fd0 = 0, valid_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: pops the scoreboard on every accepted word, counts frame_done cycles
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_done) fd_cnt++;
      if (prev_stall && wr_if.wr_valid)
        check("stall_stable", 32'({wr_if.wr_addr, wr_if.wr_data}), 32'(prev_word));
      prev_stall = wr_if.wr_valid && !wr_if.wr_ready;
      prev_word  = {wr_if.wr_addr, wr_if.wr_data};
      if (wr_if.wr_valid && wr_if.wr_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h expected none", {wr_if.wr_addr, wr_if.wr_data});
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_word", 32'({wr_if.wr_addr, wr_if.wr_data}), 32'(mon_e));
        end
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic step(input bit e, input bit p, input bit fs, input bit rdy);
    @(posedge clk);
    #1;
    ena = e;
    edge_px = p;
    frame_start = fs;
    wr_if.wr_ready = rdy;
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) step(1'b0, 1'b0, 1'b0, rdy);
  endtask

  // pattern 0: all ones; pattern 1: checkerboard px = (row+col)&1
  function automatic bit px_val(input int pat, input int r, input int c);
    return (pat == 0) ? 1'b1 : 1'((r + c) & 1);
  endfunction

  task automatic push_exp(input int pat, input int n_keep);
    logic [15:0] w;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 2; k++) begin
        if (pat == 0)          w = (k == 0) ? 16'hFFFF : 16'h000F;
        else if (r % 2 == 0)   w = (k == 0) ? 16'hAAAA : 16'h000A;
        else                   w = (k == 0) ? 16'h5555 : 16'h0005;
        if (r * 2 + k < n_keep) exp_q.push_back({AW'(r * 2 + k), w});
      end
    end
  endtask

  // frame_start (optionally with a strobe that must be ignored), SKIP strobes of ones, then the frame
  task automatic run_frame(input int pat, input int ready_from, input bit fs_ena);
    step(fs_ena, 1'b1, 1'b1, ready_from == 0);
    for (int i = 0; i < 22; i++) step(1'b1, 1'b1, 1'b0, ready_from == 0);
    for (int i = 0; i < 60; i++) step(1'b1, px_val(pat, i / 20, i % 20), 1'b0, i >= ready_from);
  endtask

  task automatic end_frame(input string name, input int exp_ec);
    idle(6, 1'b1);
    @(negedge clk);
    check({name, "_frame_done"}, 32'(fd_cnt - fd0), 32'd1);
    check({name, "_edge_count"}, 32'(edge_count), 32'(exp_ec));
    check({name, "_state_done"}, 32'(dbg_state), 32'd3);
  endtask

  initial begin
    wr_if.wr_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wr_valid", 32'(wr_if.wr_valid), 32'd0);
    check("rst_wr_addr", 32'(wr_if.wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_if.wr_data), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_edge_count", 32'(edge_count), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2, 1'b1);

    // all-ones frame, then strobes in DONE must produce nothing
    push_exp(0, 6);
    fd0 = fd_cnt;
    run_frame(0, 0, 1'b0);
    end_frame("ones", EC_EN ? 60 : 0);
    check("ones_overflow", 32'(overflow), 32'd0);
    repeat (30) step(1'b1, 1'b1, 1'b0, 1'b1);
    idle(4, 1'b1);
    @(negedge clk);
    check("done_ignores_ena", 32'(fd_cnt - fd0), 32'd1);

    // checkerboard; skip strobes are ones and must not leak into words
    push_exp(1, 6);
    fd0 = fd_cnt;
    run_frame(1, 0, 1'b0);
    end_frame("checker", EC_EN ? 30 : 0);

    // FIFO full, then a push and a pop in the same cycle: nothing dropped
    push_exp(0, 6);
    fd0 = fd_cnt;
    run_frame(0, 55, 1'b0);
    end_frame("full_pushpop", EC_EN ? 60 : 0);
    check("full_pushpop_no_overflow", 32'(overflow), 32'd0);

    // wr_ready low for the whole frame: words 0..3 kept, 4 and 5 dropped
    push_exp(0, 4);
    fd0 = fd_cnt;
    run_frame(0, 1000, 1'b0);
    idle(3, 1'b0);
    @(negedge clk);
    check("ovf_overflow", 32'(overflow), 32'd1);
    check("ovf_valid", 32'(wr_if.wr_valid), 32'd1);
    check("ovf_head_addr", 32'(wr_if.wr_addr), 32'd0);
    check("ovf_edge_count", 32'(edge_count), EC_EN ? 32'd60 : 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("fs_clears_overflow", 32'(overflow), 32'd0);
    check("fs_keeps_fifo", 32'(wr_if.wr_valid), 32'd1);
    check("fs_state_skip", 32'(dbg_state), 32'd1);
    push_exp(1, 6);
    fd0 = fd_cnt;
    run_frame(1, 0, 1'b0);
    end_frame("after_ovf", EC_EN ? 30 : 0);

    // frame_start mid-row with a strobe in the same cycle
    step(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 22; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    push_exp(1, 6);
    fd0 = fd_cnt;
    run_frame(1, 0, 1'b1);
    end_frame("restart", EC_EN ? 30 : 0);

    // reset mid-frame with 2 words queued; also checks first-word latency
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 22; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      if (i == 15) begin
        @(negedge clk);
        check("latency_before", 32'(wr_if.wr_valid), 32'd0);
      end
      if (i == 16) begin
        @(negedge clk);
        check("latency_after", 32'(wr_if.wr_valid), 32'd1);
      end
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_wr_valid", 32'(wr_if.wr_valid), 32'd0);
    check("arst_wr_data", 32'(wr_if.wr_data), 32'd0);
    check("arst_overflow", 32'(overflow), 32'd0);
    check("arst_edge_count", 32'(edge_count), 32'd0);
    check("arst_state", 32'(dbg_state), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    valid_seen = 0;
    for (int i = 0; i < 60; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      if (wr_if.wr_valid) valid_seen++;
    end
    check("no_writes_after_reset", 32'(valid_seen), 32'd0);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) idle(1, 1'b1);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
